// File: rtl/spatz_barrier_responder.sv
// Per-core stage behind the cluster hardware barrier: answers released barrier
// accesses locally with the generation count and passes all other traffic through.
module spatz_barrier_responder #(
  parameter int unsigned          NrPorts        = 4,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 64,
  parameter int unsigned          MaxOutstanding = 8,
  parameter logic [AddrWidth-1:0] BarrierOffset  = AddrWidth'(32'h0000_0058)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [AddrWidth-1:0]           periph_base_i,
  input  logic [NrPorts-1:0]             in_q_valid_i,
  input  logic [NrPorts*AddrWidth-1:0]   in_q_addr_i,
  input  logic [NrPorts-1:0]             in_q_write_i,
  input  logic [NrPorts*DataWidth-1:0]   in_q_data_i,
  output logic [NrPorts-1:0]             in_q_ready_o,
  output logic [NrPorts-1:0]             in_p_valid_o,
  output logic [NrPorts*DataWidth-1:0]   in_p_data_o,
  input  logic [NrPorts-1:0]             in_p_ready_i,
  output logic [NrPorts-1:0]             out_q_valid_o,
  output logic [NrPorts*AddrWidth-1:0]   out_q_addr_o,
  output logic [NrPorts-1:0]             out_q_write_o,
  output logic [NrPorts*DataWidth-1:0]   out_q_data_o,
  input  logic [NrPorts-1:0]             out_q_ready_i,
  input  logic [NrPorts-1:0]             out_p_valid_i,
  input  logic [NrPorts*DataWidth-1:0]   out_p_data_i,
  output logic [NrPorts-1:0]             out_p_ready_o,
  output logic [31:0]                    generation_o
);

  localparam int unsigned         CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [0:0]          StIdle   = 1'b0;
  localparam logic [0:0]          StResp   = 1'b1;

  logic [0:0]           state       [NrPorts];
  logic [CntWidth-1:0]  outstanding [NrPorts];
  logic [DataWidth-1:0] rsp_data    [NrPorts];
  logic [NrPorts-1:0]   arrived;
  logic [NrPorts-1:0]   hit;
  logic [NrPorts-1:0]   accept;
  logic [NrPorts-1:0]   pass_ok;
  logic [NrPorts-1:0]   q_hs;
  logic [NrPorts-1:0]   p_hs;
  logic [AddrWidth-1:0] barrier_addr;
  logic                 episode_done;

  assign barrier_addr  = periph_base_i + BarrierOffset;
  assign out_q_addr_o  = in_q_addr_i;
  assign out_q_write_o = in_q_write_i;
  assign out_q_data_o  = in_q_data_i;
  assign episode_done  = &(arrived | accept);

  // Per-port hit detection, request gating and response routing.
  always_comb begin
    hit           = {NrPorts{1'b0}};
    accept        = {NrPorts{1'b0}};
    pass_ok       = {NrPorts{1'b0}};
    q_hs          = {NrPorts{1'b0}};
    p_hs          = {NrPorts{1'b0}};
    in_q_ready_o  = {NrPorts{1'b0}};
    out_q_valid_o = {NrPorts{1'b0}};
    in_p_valid_o  = {NrPorts{1'b0}};
    out_p_ready_o = {NrPorts{1'b0}};
    in_p_data_o   = {(NrPorts*DataWidth){1'b0}};
    for (int unsigned i = 0; i < NrPorts; i++) begin
      hit[i]     = in_q_valid_i[i] && (in_q_addr_i[i*AddrWidth +: AddrWidth] == barrier_addr);
      pass_ok[i] = !rst_i && (state[i] == StIdle) && (outstanding[i] != MaxCnt);
      // A barrier access is only answered once all earlier pass-through traffic has drained.
      accept[i]  = !rst_i && (state[i] == StIdle) && hit[i] &&
                   (outstanding[i] == {CntWidth{1'b0}}) && !arrived[i];
      out_q_valid_o[i] = in_q_valid_i[i] && !hit[i] && pass_ok[i];
      if (hit[i]) begin
        in_q_ready_o[i] = accept[i];
      end else begin
        in_q_ready_o[i] = out_q_ready_i[i] && pass_ok[i];
      end
      q_hs[i] = out_q_valid_o[i] && out_q_ready_i[i];
      if (rst_i) begin
        in_p_valid_o[i]  = 1'b0;
        out_p_ready_o[i] = 1'b0;
      end else if (state[i] == StResp) begin
        in_p_valid_o[i]                       = 1'b1;
        in_p_data_o[i*DataWidth +: DataWidth] = rsp_data[i];
        out_p_ready_o[i]                      = 1'b0;
      end else begin
        in_p_valid_o[i]                       = out_p_valid_i[i];
        in_p_data_o[i*DataWidth +: DataWidth] = out_p_data_i[i*DataWidth +: DataWidth];
        out_p_ready_o[i]                      = in_p_ready_i[i];
      end
      p_hs[i] = out_p_valid_i[i] && out_p_ready_o[i];
    end
  end

  // Per-port FSM, outstanding counters, arrival tracking and generation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        state[i]       <= StIdle;
        outstanding[i] <= {CntWidth{1'b0}};
        rsp_data[i]    <= {DataWidth{1'b0}};
      end
      arrived      <= {NrPorts{1'b0}};
      generation_o <= 32'd0;
    end else begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        case (state[i])
          StIdle: begin
            if (accept[i]) begin
              state[i]    <= StResp;
              rsp_data[i] <= DataWidth'(generation_o);
            end
          end
          StResp: begin
            if (in_p_ready_i[i]) begin
              state[i] <= StIdle;
            end
          end
          default: state[i] <= StIdle;
        endcase
        if (q_hs[i] && !p_hs[i]) begin
          outstanding[i] <= outstanding[i] + CntWidth'(1);
        end else if (!q_hs[i] && p_hs[i]) begin
          outstanding[i] <= outstanding[i] - CntWidth'(1);
        end
      end
      // Ports accepting in the completing cycle have already captured the old generation.
      if (episode_done) begin
        arrived      <= {NrPorts{1'b0}};
        generation_o <= generation_o + 32'd1;
      end else begin
        arrived <= arrived | accept;
      end
    end
  end

endmodule

// File: tb/tb_spatz_barrier_responder.sv
// Self-checking bench for spatz_barrier_responder: vector table, directed
// corner-case sequences and randomized traffic against a behavioural model.
module tb_spatz_barrier_responder;
  localparam int          NP   = 4;
  localparam int          AW   = 32;
  localparam int          DW   = 64;
  localparam int          MAXO = 8;
  localparam logic [31:0] OFF  = 32'h0000_0058;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    periph_base;
  logic [NP-1:0]    in_q_valid, in_q_write, in_q_ready, in_p_valid, in_p_ready;
  logic [NP*AW-1:0] in_q_addr, out_q_addr;
  logic [NP*DW-1:0] in_q_data, in_p_data, out_q_data, out_p_data;
  logic [NP-1:0]    out_q_valid, out_q_write, out_q_ready, out_p_valid, out_p_ready;
  logic [31:0]      generation;

  spatz_barrier_responder #(
    .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO), .BarrierOffset(OFF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .periph_base_i(periph_base),
    .in_q_valid_i(in_q_valid), .in_q_addr_i(in_q_addr), .in_q_write_i(in_q_write),
    .in_q_data_i(in_q_data), .in_q_ready_o(in_q_ready),
    .in_p_valid_o(in_p_valid), .in_p_data_o(in_p_data), .in_p_ready_i(in_p_ready),
    .out_q_valid_o(out_q_valid), .out_q_addr_o(out_q_addr), .out_q_write_o(out_q_write),
    .out_q_data_o(out_q_data), .out_q_ready_i(out_q_ready),
    .out_p_valid_i(out_p_valid), .out_p_data_i(out_p_data), .out_p_ready_o(out_p_ready),
    .generation_o(generation)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: per-port in-flight count, pending local answer, arrival set.
  int          m_outst [NP];
  bit          m_pend  [NP];
  logic [63:0] m_pdata [NP];
  bit          m_arr   [NP];
  logic [31:0] m_gen;

  typedef struct packed {
    logic v, bar, oqr, opv, ipr;
    logic iqr, oqv, ipv, opr;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int port, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s port %0d: got %h, expected %h at %0t", name, port, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bar_addr();
    return periph_base + OFF;
  endfunction

  function automatic bit is_hit(int i);
    return in_q_valid[i] && (in_q_addr[i*AW +: AW] == bar_addr());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_outst[i] = 0; m_pend[i] = 1'b0; m_pdata[i] = 64'd0; m_arr[i] = 1'b0;
    end
    m_gen = 32'd0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NP; i++) begin
      logic eiqr, eoqv, eipv, eopr;
      logic [63:0] eipd;
      bit h, room;
      h = is_hit(i);
      room = (m_outst[i] < MAXO);
      eipd = 64'd0; eopr = 1'b0;
      if (rst) begin
        eiqr = 1'b0; eoqv = 1'b0; eipv = 1'b0;
      end else if (m_pend[i]) begin
        eiqr = 1'b0; eoqv = 1'b0; eipv = 1'b1; eipd = m_pdata[i]; eopr = 1'b0;
      end else begin
        eiqr = h ? (m_outst[i] == 0 && !m_arr[i]) : (out_q_ready[i] && room);
        eoqv = in_q_valid[i] && !h && room;
        eipv = out_p_valid[i]; eipd = out_p_data[i*DW +: DW]; eopr = in_p_ready[i];
      end
      chk("in_q_ready", i, 64'(in_q_ready[i]), 64'(eiqr));
      chk("out_q_valid", i, 64'(out_q_valid[i]), 64'(eoqv));
      chk("in_p_valid", i, 64'(in_p_valid[i]), 64'(eipv));
      chk("out_q_addr", i, 64'(out_q_addr[i*AW +: AW]), 64'(in_q_addr[i*AW +: AW]));
      if (!rst) chk("out_p_ready", i, 64'(out_p_ready[i]), 64'(eopr));
      if (!rst && eipv) chk("in_p_data", i, in_p_data[i*DW +: DW], eipd);
    end
    chk("generation", 0, 64'(generation), 64'(m_gen));
  endtask

  task automatic update_model();
    bit all;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NP; i++) begin
        bit h;
        h = is_hit(i);
        if (m_pend[i]) begin
          if (in_p_ready[i]) m_pend[i] = 1'b0;
        end else begin
          if (h && m_outst[i] == 0 && !m_arr[i]) begin
            m_pend[i] = 1'b1; m_pdata[i] = {32'd0, m_gen}; m_arr[i] = 1'b1;
          end
          if (!h && in_q_valid[i] && out_q_ready[i] && m_outst[i] < MAXO) m_outst[i]++;
          if (out_p_valid[i] && in_p_ready[i]) m_outst[i]--;
        end
      end
      all = 1'b1;
      for (int i = 0; i < NP; i++) if (!m_arr[i]) all = 1'b0;
      if (all) begin
        m_gen = m_gen + 32'd1;
        for (int i = 0; i < NP; i++) m_arr[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_q_valid = '0; in_q_write = '0; in_q_data = '0;
    out_q_ready = '0; out_p_valid = '0; out_p_data = '0; in_p_ready = '1;
    for (int i = 0; i < NP; i++) in_q_addr[i*AW +: AW] = bar_addr() + 32'h100 + 32'(i);
  endtask

  task automatic set_port(int i, bit v, bit bar);
    in_q_valid[i] = v;
    in_q_addr[i*AW +: AW] = bar ? bar_addr() : bar_addr() + 32'h4;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 299) == 0);
    for (int i = 0; i < NP; i++) begin
      in_q_valid[i] = 1'($urandom_range(0, 1));
      in_q_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? bar_addr() : $urandom();
      in_q_write[i] = 1'($urandom_range(0, 1));
      in_q_data[i*DW +: DW] = {$urandom(), $urandom()};
      out_q_ready[i] = 1'($urandom_range(0, 1));
      in_p_ready[i] = ($urandom_range(0, 3) != 0);
      out_p_valid[i] = (m_outst[i] > 0) && ($urandom_range(0, 2) == 0);
      out_p_data[i*DW +: DW] = {$urandom(), $urandom()};
    end
  endtask

  initial begin
    //          v   bar  oqr  opv  ipr  iqr  oqv  ipv  opr
    tbl[0] = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};
    tbl[1] = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    tbl[2] = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[3] = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1};
    tbl[4] = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[5] = {1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1};
    tbl[6] = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0};

    periph_base = 32'hFFFF_FFE0;  // base + offset wraps past 2^32
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    // Single-cycle vectors on port 1, withdrawn before the clock edge.
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      set_port(1, tbl[k].v, tbl[k].bar);
      out_q_ready[1] = tbl[k].oqr;
      out_p_valid[1] = tbl[k].opv;
      out_p_data[1*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(k);
      in_p_ready[1] = tbl[k].ipr;
      #1;
      chk("tbl_in_q_ready", k, 64'(in_q_ready[1]), 64'(tbl[k].iqr));
      chk("tbl_out_q_valid", k, 64'(out_q_valid[1]), 64'(tbl[k].oqv));
      chk("tbl_in_p_valid", k, 64'(in_p_valid[1]), 64'(tbl[k].ipv));
      chk("tbl_out_p_ready", k, 64'(out_p_ready[1]), 64'(tbl[k].opr));
      if (tbl[k].opv) chk("tbl_in_p_data", k, in_p_data[1*DW +: DW], 64'hA5A5_0000_0000_0000 + 64'(k));
      #1;
      idle_inputs();
      @(negedge clk);
    end

    // All four ports hit together: answered with 0, generation becomes 1.
    idle_inputs();
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1);
    out_q_ready = '1;
    step();
    idle_inputs();
    in_p_ready = '0;
    #1;
    chk("all_hit_valid", 0, 64'(in_p_valid), 64'hF);
    chk("all_hit_data", 3, in_p_data[3*DW +: DW], 64'd0);
    chk("all_hit_gen", 0, 64'(generation), 64'd1);
    step();
    in_p_ready = '1;
    step();

    // Port 2: three loads in flight, then a hit that waits for them to drain.
    idle_inputs();
    set_port(2, 1'b1, 1'b0);
    out_q_ready[2] = 1'b1;
    repeat (3) step();
    set_port(2, 1'b1, 1'b1);
    repeat (3) step();
    #1 chk("p2_stall", 2, 64'(in_q_ready[2]), 64'd0);
    out_p_valid[2] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      out_p_data[2*DW +: DW] = 64'h1111 * 64'(r + 1);
      step();
    end
    out_p_valid[2] = 1'b0;
    step();
    set_port(2, 1'b0, 1'b0);
    in_p_ready[2] = 1'b0;
    #1 chk("p2_rsp_data", 2, in_p_data[2*DW +: DW], 64'd1);
    step();
    in_p_ready[2] = 1'b1;
    step();

    // Port 0 hits twice; the second waits for ports 1 and 3 to close the episode.
    idle_inputs();
    set_port(0, 1'b1, 1'b1);
    step(); step();
    #1 chk("p0_second_stall", 0, 64'(in_q_ready[0]), 64'd0);
    step();
    set_port(1, 1'b1, 1'b1); set_port(3, 1'b1, 1'b1);
    step();
    set_port(1, 1'b0, 1'b0); set_port(3, 1'b0, 1'b0);
    step();
    set_port(0, 1'b0, 1'b0);
    in_p_ready[0] = 1'b0;
    #1 chk("p0_second_data", 0, in_p_data[0*DW +: DW], 64'd2);
    step();
    idle_inputs();
    step();

    // Port 1 response held for five cycles while port 0 keeps passing traffic.
    set_port(1, 1'b1, 1'b1);
    step();
    set_port(1, 1'b1, 1'b0);
    in_p_ready[1] = 1'b0;
    set_port(0, 1'b1, 1'b0);
    out_q_ready = '1;
    out_p_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("p1_held_data", 1, in_p_data[1*DW +: DW], 64'd2);
      step();
    end
    idle_inputs();
    step();
    out_p_valid[0] = 1'b1;
    repeat (5) step();
    idle_inputs();

    // Port 3 fills to the outstanding limit, then drains.
    set_port(3, 1'b1, 1'b0);
    out_q_ready[3] = 1'b1;
    repeat (MAXO) step();
    #1 chk("p3_full_ready", 3, 64'(in_q_ready[3]), 64'd0);
    step();
    idle_inputs();
    out_p_valid[3] = 1'b1;
    repeat (MAXO) step();
    idle_inputs();

    // Reset while ports 0 and 3 hold local responses.
    set_port(0, 1'b1, 1'b1); set_port(3, 1'b1, 1'b1);
    step();
    idle_inputs();
    in_p_ready = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_p_valid", 0, 64'(in_p_valid), 64'd0);
    chk("rst_generation", 0, 64'(generation), 64'd0);
    step();
    set_port(1, 1'b1, 1'b1);
    in_p_ready = '1;
    #1 chk("rst_arrived_clear", 1, 64'(in_q_ready[1]), 64'd1);
    step();
    idle_inputs();
    step();

    // Randomized traffic against the model.
    periph_base = 32'h1000_0000;
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
